compressor_ingress_arbiter: RTL
===============================

# compressor_ingress_arbiter

Packet-granular round-robin arbiter that shares the single 256-bit compressor ingress stream among NUM_PORTS AXI-Stream sources. It sits directly in front of the compressor controller's tvalid/tready/tlast/data_in interface. It never interleaves beats of different packets. It tags header beats for downstream use and truncates runaway packets with no tlast.

## Interface
Parameters:
- NUM_PORTS, 4, number of source ports (2..8).
- BURST_WIDTH, 256, beat width in bits.
- MAX_BEATS, 64, maximum beats per packet including header (>= 5).

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- arb_en  in  1  when low, no new grant is issued; a packet in flight completes.
- s_tvalid  in  NUM_PORTS  per-port beat valid.
- s_tlast  in  NUM_PORTS  per-port last beat.
- s_tdata  in  NUM_PORTS*BURST_WIDTH  per-port beat; port i occupies bits [i*BURST_WIDTH +: BURST_WIDTH].
- s_tready  out  NUM_PORTS  per-port ready.
- m_tvalid  out  1  beat valid to compressor.
- m_tlast  out  1  last beat, possibly forced.
- m_tdata  out  BURST_WIDTH  beat to compressor.
- m_tready  in  1  compressor ready (its !full_infifo).
- m_hdr  out  1  high on beats 0..3 of the current packet.
- grant  out  clog2(NUM_PORTS)  index of the owning port; valid while busy.
- busy  out  1  a port owns the output (state PKT or DRAIN).
- err_overlong  out  1  one-cycle pulse when a packet is truncated.

## Operation
- States: ARB, PKT, DRAIN. Registered: state, grant, last_grant, beat_cnt (clog2(MAX_BEATS)+1 bits), err_overlong.
- ARB: m_tvalid=0, s_tready=0.
  - If arb_en and any s_tvalid, choose the first requesting port searching upward cyclically from last_grant+1.
  - Register that port as grant, clear beat_cnt, go to PKT.
- PKT: output is combinationally muxed from port grant.
  - m_tvalid=s_tvalid[grant], m_tdata=s_tdata[grant], s_tready[grant]=m_tready. All other s_tready are 0.
  - A beat is accepted when m_tvalid && m_tready. On each accepted beat, beat_cnt increments.
  - m_hdr = m_tvalid && (beat_cnt < 4).
  - m_tlast = s_tlast[grant] on an accepted beat, or forced to 1 when beat_cnt == MAX_BEATS-1.
  - Accepted beat with s_tlast[grant]: set last_grant=grant, go to ARB.
  - Accepted beat at beat_cnt == MAX_BEATS-1 without s_tlast: drive m_tlast=1, pulse err_overlong the next cycle, go to DRAIN.
  - A source tlast on exactly beat MAX_BEATS is not an error.
- DRAIN: m_tvalid=0, s_tready[grant]=1, other ports 0.
  - Beats from the owning port are discarded.
  - On s_tvalid[grant] && s_tlast[grant], set last_grant=grant and go to ARB.
- arb_en is sampled only in ARB. Deasserting it in PKT or DRAIN has no effect on the packet in flight.
- Output is zero when not PKT: m_tdata=0, m_tlast=0, m_hdr=0.

## Timing
- Reset values: state=ARB, last_grant=NUM_PORTS-1 (so port 0 wins first), grant=0, beat_cnt=0. All outputs are 0.
- Reset mid-packet: the next cycle is ARB with no output beat. The partial packet is abandoned and its remaining source beats are not drained.
- Grant latency: one cycle. A request seen in ARB at cycle N allows its first beat to transfer at cycle N+1 at the earliest.
- Each packet boundary costs exactly one ARB bubble cycle. Back-to-back packets therefore need at least one idle cycle between them.
- In PKT, data/valid/ready paths are purely combinational (zero latency). There is no registered beat storage.
- m_tready low holds the beat. The source must keep data stable under AXI rules, and the arbiter adds no buffering.
- A source dropping tvalid mid-packet keeps ownership; there is no timeout.
- Simultaneous requests are resolved by the round-robin pointer only. There is no fixed priority except immediately after reset.
- err_overlong is high for exactly one cycle: the cycle after the truncating beat.

## Test plan
- Single port, 6-beat packet on port 2, m_tready=1 → grant=2 one cycle after s_tvalid; 6 beats out in order; m_hdr high on beats 0..3 only; m_tlast on beat 6; state returns to ARB.
- All 4 ports hold 2-beat packets continuously from reset → grant sequence 0,1,2,3,0; one bubble cycle between packets; no interleaving.
- Port 1 streaming, m_tready toggles 1,0,0,1 per cycle → beats advance only when m_tready=1; s_tready[1] follows m_tready; s_tready[0,2,3]=0 throughout.
- MAX_BEATS=8, port 0 sends 11 beats with tlast on beat 11 → 8 beats out, m_tlast forced on beat 8, err_overlong pulse one cycle later; beats 9..11 absorbed with m_tvalid=0; back to ARB after beat 11.
- MAX_BEATS=8, 8-beat packet with tlast on beat 8 → no err_overlong; normal return to ARB.
- arb_en low while port 3 requests → no grant, busy=0. Raise arb_en → grant=3 next cycle. Drop arb_en mid-packet → packet completes, then no new grant. Separately, assert reset on beat 3 of 6 → all outputs 0 next cycle, state ARB.

Source files
------------

// File: rtl/compressor_ingress_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : compressor_ingress_arbiter
// Purpose  : Packet-granular round-robin arbiter sharing one AXI-Stream
//            compressor ingress among NUM_PORTS sources. Whole packets only,
//            header-beat tagging, truncation of runaway packets.
// Revision : 1.0  initial release
// ============================================================================
module compressor_ingress_arbiter #(
    parameter int NUM_PORTS   = 4,
    parameter int BURST_WIDTH = 256,
    parameter int MAX_BEATS   = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             arb_en,
    input  logic [NUM_PORTS-1:0]             s_tvalid,
    input  logic [NUM_PORTS-1:0]             s_tlast,
    input  logic [NUM_PORTS*BURST_WIDTH-1:0] s_tdata,
    output logic [NUM_PORTS-1:0]             s_tready,
    output logic                             m_tvalid,
    output logic                             m_tlast,
    output logic [BURST_WIDTH-1:0]           m_tdata,
    input  logic                             m_tready,
    output logic                             m_hdr,
    output logic [$clog2(NUM_PORTS)-1:0]     grant,
    output logic                             busy,
    output logic                             err_overlong
);

    localparam int GW = $clog2(NUM_PORTS);
    localparam int CW = $clog2(MAX_BEATS) + 1;
    localparam logic [CW-1:0] LAST_CNT  = CW'(MAX_BEATS - 1);
    localparam logic [CW-1:0] HDR_BEATS = CW'(4);

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_PKT   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [GW-1:0]  grant_q, grant_d;
    logic [GW-1:0]  last_grant_q, last_grant_d;
    logic [CW-1:0]  beat_cnt_q, beat_cnt_d;
    logic           err_q, err_d;

    logic           w_found;
    logic [GW-1:0]  w_pick;
    logic [GW-1:0]  w_idx;
    logic           w_cur_valid;
    logic           w_cur_last;

    // Round-robin search: first requester strictly after last_grant, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            w_idx = GW'((int'(last_grant_q) + i) % NUM_PORTS);
            if (!w_found && s_tvalid[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_cur_valid = s_tvalid[grant_q];
    assign w_cur_last  = s_tlast[grant_q];

    // Next-state logic and the combinational data/handshake path of the owner.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        err_d        = 1'b0;
        m_tvalid     = 1'b0;
        m_tlast      = 1'b0;
        m_tdata      = '0;
        m_hdr        = 1'b0;
        s_tready     = '0;
        case (state_q)
            ST_ARB: begin
                if (arb_en && w_found) begin
                    grant_d    = w_pick;
                    beat_cnt_d = '0;
                    state_d    = ST_PKT;
                end
            end
            ST_PKT: begin
                m_tvalid          = w_cur_valid;
                m_tdata           = s_tdata[int'(grant_q)*BURST_WIDTH +: BURST_WIDTH];
                s_tready[grant_q] = m_tready;
                m_hdr             = w_cur_valid && (beat_cnt_q < HDR_BEATS);
                // The final permitted beat always closes the packet downstream.
                m_tlast           = w_cur_valid && (w_cur_last || (beat_cnt_q == LAST_CNT));
                if (w_cur_valid && m_tready) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (w_cur_last) begin
                        last_grant_d = grant_q;
                        state_d      = ST_ARB;
                    end else if (beat_cnt_q == LAST_CNT) begin
                        err_d   = 1'b1;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Swallow the rest of a truncated packet until its own tlast.
                s_tready[grant_q] = 1'b1;
                if (w_cur_valid && w_cur_last) begin
                    last_grant_d = grant_q;
                    state_d      = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    // State registers; reset points the round-robin pointer so port 0 wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_ARB;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_PORTS - 1);
            beat_cnt_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            err_q        <= err_d;
        end
    end

    assign grant        = grant_q;
    assign busy         = (state_q != ST_ARB);
    assign err_overlong = err_q;

endmodule
`default_nettype wire
